// File: rtl/fsm_step_decoder.sv
// Step decoder for a 7-state ring FSM: recovers one-hot advance events,
// flags illegal codes/jumps, counts laps and resyncs after a fault.
module fsm_step_decoder #(
    parameter int LAP_W        = 8,
    parameter int RESYNC_STATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       state,
    input  logic             clear_err,
    output logic [6:0]       ev,
    output logic             ev_valid,
    output logic             hold,
    output logic             illegal,
    output logic             err_sticky,
    output logic [LAP_W-1:0] lap_count,
    output logic             sync
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAULT
    } mode_t;

    localparam logic [2:0] RESYNC = 3'(RESYNC_STATE);

    mode_t      mode;
    logic [2:0] prev;
    logic [2:0] nxt;
    logic       bad_code;
    logic       is_same;
    logic       is_next;

    always_comb begin
        nxt      = (prev == 3'd6) ? 3'd0 : prev + 3'd1;
        bad_code = (state == 3'd7);
        is_same  = (state == prev);
        is_next  = (state == nxt);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode       <= IDLE;
            prev       <= 3'd0;
            ev         <= '0;
            ev_valid   <= 1'b0;
            hold       <= 1'b0;
            illegal    <= 1'b0;
            err_sticky <= 1'b0;
            lap_count  <= '0;
            sync       <= 1'b0;
        end else begin
            ev       <= '0;
            ev_valid <= 1'b0;
            hold     <= 1'b0;
            illegal  <= 1'b0;
            // a same-edge illegal below overrides this clear
            if (clear_err)
                err_sticky <= 1'b0;
            if (in_valid) begin
                unique case (mode)
                    IDLE: begin
                        if (bad_code) begin
                            illegal    <= 1'b1;
                            err_sticky <= 1'b1;
                            mode       <= FAULT;
                        end else begin
                            prev <= state;
                            mode <= TRACK;
                            sync <= 1'b1;
                        end
                    end
                    TRACK: begin
                        unique case (1'b1)
                            bad_code: begin
                                illegal    <= 1'b1;
                                err_sticky <= 1'b1;
                                mode       <= FAULT;
                                sync       <= 1'b0;
                            end
                            is_same: begin
                                ev_valid <= 1'b1;
                                hold     <= 1'b1;
                            end
                            is_next: begin
                                ev_valid <= 1'b1;
                                ev       <= 7'b1 << prev;
                                prev     <= state;
                                if (prev == 3'd6 && lap_count != '1)
                                    lap_count <= lap_count + 1'b1;
                            end
                            default: begin
                                illegal    <= 1'b1;
                                err_sticky <= 1'b1;
                                mode       <= FAULT;
                                sync       <= 1'b0;
                            end
                        endcase
                    end
                    FAULT: begin
                        if (state == RESYNC) begin
                            prev <= RESYNC;
                            mode <= TRACK;
                            sync <= 1'b1;
                        end
                    end
                    default: mode <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsm_step_decoder.sv
// Scoreboard bench for fsm_step_decoder: directed plan plus random
// streams, checked against a lap/event model of the ring protocol.
module tb_fsm_step_decoder;

    localparam int LW  = 2;
    localparam int RS  = 0;
    localparam int MAXL = (1 << LW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [2:0]    state;
    logic          clear_err;
    logic [6:0]    ev;
    logic          ev_valid;
    logic          hold;
    logic          illegal;
    logic          err_sticky;
    logic [LW-1:0] lap_count;
    logic          sync;

    fsm_step_decoder #(.LAP_W(LW), .RESYNC_STATE(RS)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .state(state), .clear_err(clear_err), .ev(ev),
        .ev_valid(ev_valid), .hold(hold), .illegal(illegal),
        .err_sticky(err_sticky), .lap_count(lap_count), .sync(sync)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ev;
        int evv;
        int hold;
        int ill;
        int sticky;
        int lap;
        int sync;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // model state: have a reference / in fault episode
    bit m_tracking = 0;
    bit m_fault    = 0;
    int m_prev     = 0;
    int m_laps     = 0;
    bit m_sticky   = 0;

    task automatic cmp(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic exp_t model(bit r, bit v, int s, bit c);
        exp_t e;
        e = '{0, 0, 0, 0, 0, 0, 0};
        if (!r) begin
            m_tracking = 0;
            m_fault    = 0;
            m_prev     = 0;
            m_laps     = 0;
            m_sticky   = 0;
        end else begin
            if (c) m_sticky = 0;
            if (v) begin
                if (m_fault) begin
                    if (s == RS) begin
                        m_prev = s;
                        m_fault = 0;
                        m_tracking = 1;
                    end
                end else if (!m_tracking) begin
                    if (s == 7) begin
                        e.ill = 1;
                        m_sticky = 1;
                        m_fault = 1;
                    end else begin
                        m_prev = s;
                        m_tracking = 1;
                    end
                end else if (s == m_prev) begin
                    e.evv  = 1;
                    e.hold = 1;
                end else if (s != 7 && s == (m_prev + 1) % 7) begin
                    e.evv = 1;
                    e.ev  = 1 << m_prev;
                    if (m_prev == 6 && m_laps < MAXL) m_laps++;
                    m_prev = s;
                end else begin
                    e.ill = 1;
                    m_sticky = 1;
                    m_fault = 1;
                    m_tracking = 0;
                end
            end
        end
        e.sticky = m_sticky;
        e.lap    = m_laps;
        e.sync   = m_tracking;
        return e;
    endfunction

    task automatic drive(bit r, bit v, int s, bit c);
        @(negedge clock);
        reset     = r;
        in_valid  = v;
        state     = 3'(s);
        clear_err = c;
        q.push_back(model(r, v, s, c));
    endtask

    task automatic smp(int s);
        drive(1, 1, s, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("ev", int'(ev), e.ev);
                cmp("ev_valid", int'(ev_valid), e.evv);
                cmp("hold", int'(hold), e.hold);
                cmp("illegal", int'(illegal), e.ill);
                cmp("err_sticky", int'(err_sticky), e.sticky);
                cmp("lap_count", int'(lap_count), e.lap);
                cmp("sync", int'(sync), e.sync);
            end
        end
    end

    initial begin : stim
        int s;
        int w;
        reset = 1'b0;
        in_valid = 1'b0;
        state = 3'd0;
        clear_err = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 1, 3, 1);
        // full walk 0..6,0
        for (int i = 0; i <= 7; i++) smp(i % 7);
        // holds at 3 then advance
        for (int i = 1; i <= 3; i++) smp(i);
        smp(3); smp(3); smp(4);
        // bad jump 2->5, ignored samples, resync
        smp(5); smp(6); smp(0); smp(1); smp(2);
        smp(5); smp(7); smp(4); smp(0); smp(1);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 0);
        // clear on same edge as an illegal jump
        drive(1, 1, 3, 1);
        drive(1, 1, 7, 1);
        smp(0);
        // four laps with idle gaps
        for (int l = 0; l < 4; l++)
            for (int i = 1; i <= 7; i++) begin
                smp(i % 7);
                if (i % 3 == 0) drive(1, 0, i, 0);
            end
        // mid-lap reset with sticky set
        smp(1); smp(2); smp(4); smp(0);
        smp(1); smp(2); smp(3); smp(4);
        drive(0, 1, 5, 0);
        smp(5); smp(6);
        // random streams
        for (int n = 0; n < 600; n++) begin
            w = $urandom_range(99);
            if (w < 55)      s = (m_prev + 1) % 7;
            else if (w < 70) s = m_prev;
            else if (w < 78) s = RS;
            else             s = $urandom_range(7);
            drive($urandom_range(99) >= 2,
                  $urandom_range(99) >= 15, s,
                  $urandom_range(99) < 6);
        end
        drive(1, 0, 0, 0);
        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(posedge clock);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_step_decoder.md
Name: fsm_step_decoder

Overview:
- Receiver-side companion to the 7-state ring next-state generator.
- The generator's ring: state s moves to (s+1) mod 7 when its advance input i_s is high; otherwise the state holds.
- This block watches the sampled 3-bit state stream from such an FSM and recovers which advance input fired each step as a one-hot event.
- It also detects illegal jumps and state code 7, counts completed laps (6->0), and resynchronises after a fault.
- Used as an on-chip monitor/checker alongside the ring FSM and as the reverse decoder in fsm testing.

Parameters:
- LAP_W, 8, width of the lap counter; the counter saturates at all ones.
- RESYNC_STATE, 0, state code (0..6) that releases FAULT back to TRACK.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- in_valid  input  1  the state sample on this cycle is meaningful.
- state  input  3  sampled ring state; legal codes are 0..6.
- clear_err  input  1  clears err_sticky.
- ev  output  7  one-hot registered event; ev[k]=1 means advance input i_k fired (k->k+1 mod 7).
- ev_valid  output  1  pulse qualifying ev; it is also high for a hold step with ev=0.
- hold  output  1  pulse; valid sample equal to the previous state.
- illegal  output  1  pulse; bad code or bad jump detected.
- err_sticky  output  1  latched illegal flag.
- lap_count  output  LAP_W  number of 6->0 transitions seen, saturating.
- sync  output  1  high while in TRACK.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM=IDLE, prev=0.
  - ev=0, ev_valid=0, hold=0, illegal=0, err_sticky=0, lap_count=0, sync=0.
  - Reset overrides every other input, including mid-sequence and in FAULT.
- Latency and pulses:
  - All outputs are registered.
  - The response to a valid sample at edge N appears after edge N and lasts exactly one cycle.
  - ev, ev_valid, hold and illegal are 0 on any cycle following in_valid=0 or following a non-reporting sample.
- in_valid=0: no state change, prev retained, lap_count retained.
- IDLE (no reference sample yet):
  - Valid sample 0..6: prev<=state, go TRACK, sync=1. No ev/hold pulse; the first sample only establishes a reference.
  - Valid sample 7: illegal=1, err_sticky<=1, go FAULT.
- TRACK (prev holds the last accepted state). For a valid sample s:
  - s==7: illegal=1, err_sticky<=1, go FAULT, sync<=0.
  - s==prev: ev_valid=1, ev=0, hold=1.
  - s==(prev+1) mod 7: ev_valid=1, ev=1<<prev, prev<=s. If prev==6 (so s==0), lap_count<=lap_count+1, saturating at 2^LAP_W-1.
  - Any other s (skips, backward steps, 6->1, etc.): illegal=1, err_sticky<=1, go FAULT, sync<=0. prev is not updated.
- FAULT:
  - Valid sample == RESYNC_STATE: prev<=RESYNC_STATE, go TRACK, sync<=1. No ev pulse; lap_count is unchanged.
  - Any other valid sample, including 7: ignored; no further illegal pulses (one pulse per fault episode).
- Arithmetic: next(prev) = 0 if prev==6, else prev+1. Code 7 is never a legal prev.
- err_sticky:
  - Set by any illegal pulse.
  - Cleared when clear_err=1 at an edge.
  - When clear_err and a new illegal condition occur at the same edge, set wins.
- lap_count is never cleared except by reset.

Test Plan:
- Reset, then valid samples 0,1,2,3,4,5,6,0:
  - The first sample gives no pulse, sync=1.
  - The next seven give ev=0000001, 0000010, 0000100, 0001000, 0010000, 0100000, 1000000 in order.
  - lap_count=1 after the 6->0 step; illegal never asserted.
- In TRACK at 3, send 3,3 then 4:
  - hold=1, ev_valid=1, ev=0 twice.
  - Then ev=0001000; prev=4.
- In TRACK at 2, send 5:
  - illegal=1 for one cycle, err_sticky=1, sync=0.
  - Send 7 and 4: no pulses.
  - Send 0: sync=1. Then send 1: ev=0000001.
- err_sticky set:
  - Pulse clear_err: err_sticky=0.
  - Apply clear_err on the same edge as an illegal sample: err_sticky stays 1.
- LAP_W=2:
  - Drive four full laps: lap_count goes 1, 2, 3, 3 (saturates).
  - Interleave in_valid=0 cycles: outputs stay idle and counting is unaffected.
- Mid-lap at state 4 with err_sticky=1: assert reset=0 for one edge.
  - All outputs 0, FSM IDLE.
  - The next valid 5 produces no ev, only sync=1.
